capture_ring_ctrl: RTL and testbench
====================================

Name: capture_ring_ctrl

Overview:
- Parametrised capture controller between the trigger unit and the SDRAM write path.
- Delays incoming samples to align them with the trigger decision, then stores a pre-trigger/post-trigger window into a circular buffer of programmable depth.
- At completion it reports the readout start address and the real trigger position.
- Also supports a free-running stream mode. Generalises the fixed 16-bit capture path to any data width, delay depth and counter width, and adds optional pre-fill trigger holdoff.

Parameters:
- DW, 16, sample data width in bits.
- CW, 32, width of depth, address and position counters.
- FIX_DLY, 3, fixed pipeline delay matching the trigger module latency (1..8).
- DLY_MAX, 16, number of taps in the programmable alignment delay; DLW = clog2(DLY_MAX).

Ports:
- core_clk  in  1  clock.
- core_rst  in  1  asynchronous reset, active-high.
- sample_en  in  1  level; a rising edge starts a capture, a low level aborts it.
- cons_mode  in  1  stream mode: no trigger, never completes.
- trig_en  in  1  trigger enable; when 0, capture ends after depth beats.
- pre_fill_req  in  1  when 1, triggers are ignored until pre_depth beats are stored.
- depth  in  CW  ring size in beats; minimum 2.
- pre_depth  in  CW  pre-trigger beats; values >= depth are clamped to depth-1.
- trig_dly  in  DLW  extra alignment delay, 0..DLY_MAX-1 cycles.
- trig_hit  in  1  trigger level, aligned with the delayed beat.
- sample_valid  in  1  raw beat strobe.
- sample_data  in  DW  raw beat data.
- capture_valid  out  1  registered store strobe.
- capture_data  out  DW  registered store data.
- wr_addr  out  CW  ring address of the current capture_valid beat.
- capture_done  out  1  one-cycle completion pulse.
- sd_saddr  out  CW  ring address of the oldest retained beat.
- trig_real_pos  out  CW  number of retained pre-trigger beats.
- busy  out  1  high in PRE, ARMED and POST.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; delay lines are not reset (no-reset shift registers).
- Delay path: sample_valid and sample_data go through FIX_DLY stages, then a DLY_MAX-tap shift register with tap select trig_dly+1. Call the result dv/dd.
- Output latency: sample_valid at cycle 0 gives capture_valid at cycle FIX_DLY+trig_dly+2.
- Accepting beat: dv=1 while state is PRE, ARMED or POST. An accepting beat produces capture_valid=1 and capture_data=dd on the next cycle.
- wr_addr:
  - Starts at 0 on the first beat.
  - Increments per beat and wraps from depth-1 to 0.
  - Setting `wrapped` whenever a beat is written at address depth-1.
- FSM states: IDLE, PRE, ARMED, POST, DONE.
- IDLE -> PRE on a sample_en rising edge. Clears pre_cnt, wr_addr, wrapped, sd_saddr and trig_real_pos.
- PRE: pre_cnt counts beats. PRE -> ARMED when pre_cnt reaches pre_depth.
- Trigger acceptance: condition is dv & trig_hit & trig_en & ~cons_mode, in ARMED, or in PRE when pre_fill_req=0.
  - The trigger beat is stored and is the first post beat.
  - trig_real_pos = min(pre_cnt, pre_depth).
  - post_cnt = 1.
  - Next state is POST.
- POST: counts beats until post_cnt = depth - pre_depth(clamped). The last beat goes to DONE.
- trig_en=0 (not stream): trigger is never accepted. Capture ends after exactly depth beats with trig_real_pos=0 and sd_saddr=0.
- DONE (one cycle):
  - capture_done=1.
  - sd_saddr = wrapped ? (last wr_addr+1) mod depth : 0.
  - Then IDLE.
  - sd_saddr and trig_real_pos hold until the next start.
- capture_done timing: asserted the cycle after the final capture_valid. No capture_valid is emitted after the final beat.
- cons_mode=1: PRE -> ARMED -> never triggers; beats stream indefinitely with wrapping wr_addr; capture_done is never asserted.
- sample_en low in any non-IDLE state: next state IDLE, no capture_done, capture_valid=0 from the next cycle, results unchanged.
- Simultaneous sample_en rise and a dv beat: the beat is not captured; only beats after entry to PRE are captured.
- Arithmetic: all counters are CW-bit unsigned, and comparisons are made against depth-1 so no overflow occurs. depth<2 is unsupported.

Decomposition:
- Shared package capture_pkg holds:
  - The state enum (IDLE/PRE/ARMED/POST/DONE).
  - The default constants DW=16, CW=32, FIX_DLY=3, DLY_MAX=16.
- One sub-module, cap_var_delay (parametrised width and tap count, variable-tap shift register).
  - Instantiated once for {valid, data}, in both the fixed and the variable stage.

Test Plan:
- depth=8, pre_depth=3, trig_dly=0, continuous valid, trig_hit on beat 10 -> trigger at wr_addr 2, 5 post beats, sd_saddr=0... checking wrap: 15 beats total, last wr_addr=6, wrapped=1 -> sd_saddr=7, trig_real_pos=3, capture_done 1 cycle after beat 15.
- depth=8, pre_depth=4, trigger on beat 2, pre_fill_req=0 -> trig_real_pos=2, 4 post beats, wrapped=0, sd_saddr=0, 6 capture_valid pulses.
- Same stimulus with pre_fill_req=1 -> trigger ignored until beat 4; the next trig_hit beat is accepted and trig_real_pos=4.
- trig_en=0, depth=5 -> exactly 5 capture_valid, capture_done, sd_saddr=0, trig_real_pos=0.
- trig_dly=5, FIX_DLY=3, single valid pulse -> capture_valid exactly 10 cycles later with matching data.
- cons_mode=1, depth=4, 10 beats -> wr_addr sequence 0,1,2,3,0,1,2,3,0,1, no capture_done.
- Mid-POST sample_en drop -> busy=0 and capture_valid=0 the next cycle, no capture_done.
- Mid-POST core_rst -> all outputs 0 immediately.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the capture ring controller: default geometry and FSM encoding.
package capture_pkg;

  localparam int CAP_DW      = 16;
  localparam int CAP_CW      = 32;
  localparam int CAP_FIX_DLY = 3;
  localparam int CAP_DLY_MAX = 16;

  typedef logic [2:0] cap_state_t;

  localparam cap_state_t ST_IDLE  = 3'd0;
  localparam cap_state_t ST_PRE   = 3'd1;
  localparam cap_state_t ST_ARMED = 3'd2;
  localparam cap_state_t ST_POST  = 3'd3;
  localparam cap_state_t ST_DONE  = 3'd4;

  // States in which delayed beats are written into the ring.
  function automatic logic is_busy_state(input cap_state_t s);
    return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/cap_var_delay.sv
// Shift register without reset; tap_sel = k selects the output delayed by k+1 cycles.
module cap_var_delay
  import capture_pkg::*;
#(
  parameter int W    = CAP_DW + 1,
  parameter int TAPS = CAP_DLY_MAX,
  localparam int SW  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic          core_clk,
  input  logic [SW-1:0] tap_sel,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);

  logic [W-1:0] sr_r [TAPS];

  // Data-path only, so no reset: contents flush out within TAPS cycles.
  always_ff @(posedge core_clk) begin
    sr_r[0] <= din;
    for (int i = 1; i < TAPS; i++) begin
      sr_r[i] <= sr_r[i-1];
    end
  end

  assign dout = sr_r[tap_sel];

endmodule

// File: rtl/capture_ring_ctrl.sv
// Aligns samples with the trigger decision and stores a pre/post-trigger window
// into a circular buffer; reports the readout start address and trigger position.
module capture_ring_ctrl
  import capture_pkg::*;
#(
  parameter int DW      = CAP_DW,
  parameter int CW      = CAP_CW,
  parameter int FIX_DLY = CAP_FIX_DLY,
  parameter int DLY_MAX = CAP_DLY_MAX,
  localparam int DLW    = $clog2(DLY_MAX)
) (
  input  logic          core_clk,
  input  logic          core_rst,
  input  logic          sample_en,
  input  logic          cons_mode,
  input  logic          trig_en,
  input  logic          pre_fill_req,
  input  logic [CW-1:0] depth,
  input  logic [CW-1:0] pre_depth,
  input  logic [DLW-1:0] trig_dly,
  input  logic          trig_hit,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_data,
  output logic          capture_valid,
  output logic [DW-1:0] capture_data,
  output logic [CW-1:0] wr_addr,
  output logic          capture_done,
  output logic [CW-1:0] sd_saddr,
  output logic [CW-1:0] trig_real_pos,
  output logic          busy
);

  localparam int FSW = (FIX_DLY > 1) ? $clog2(FIX_DLY) : 1;
  localparam logic [FSW-1:0] FIX_SEL = FSW'(FIX_DLY - 1);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

  logic [DW:0] fix_out_s;
  logic [DW:0] var_out_s;
  logic        dv_s;
  logic [DW-1:0] dd_s;

  cap_var_delay #(.W(DW + 1), .TAPS(FIX_DLY)) u_fix_dly (
    .core_clk (core_clk),
    .tap_sel  (FIX_SEL),
    .din      ({sample_valid, sample_data}),
    .dout     (fix_out_s)
  );

  cap_var_delay #(.W(DW + 1), .TAPS(DLY_MAX)) u_var_dly (
    .core_clk (core_clk),
    .tap_sel  (trig_dly),
    .din      (fix_out_s),
    .dout     (var_out_s)
  );

  assign dv_s = var_out_s[DW];
  assign dd_s = var_out_s[DW-1:0];

  cap_state_t    state_r, state_nxt_s;
  logic [CW-1:0] pre_cnt_r, pre_cnt_nxt_s;
  logic [CW-1:0] post_cnt_r, post_cnt_nxt_s;
  logic [CW-1:0] nxt_addr_r, nxt_addr_nxt_s;
  logic [CW-1:0] wr_addr_r, wr_addr_nxt_s;
  logic [CW-1:0] sd_saddr_r, sd_saddr_nxt_s;
  logic [CW-1:0] trig_pos_r, trig_pos_nxt_s;
  logic          wrapped_r, wrapped_nxt_s;
  logic          sample_en_d_r;
  logic          capture_valid_r;
  logic [DW-1:0] capture_data_r;
  logic          capture_done_r, done_nxt_s;
  logic          busy_r;

  logic [CW-1:0] pre_eff_s;
  logic [CW-1:0] post_len_s;
  logic [CW-1:0] pre_cnt_inc_s;
  logic          start_s;
  logic          abort_s;
  logic          beat_s;
  logic          trig_ok_s;
  logic          last_slot_s;
  logic          stop_s;

  assign pre_eff_s     = (pre_depth >= depth) ? (depth - ONE_C) : pre_depth;
  assign post_len_s    = depth - pre_eff_s;
  assign pre_cnt_inc_s = pre_cnt_r + {{(CW-1){1'b0}}, beat_s};
  assign start_s       = sample_en & ~sample_en_d_r;
  assign abort_s       = (state_r != ST_IDLE) & ~sample_en;
  assign beat_s        = dv_s & sample_en & is_busy_state(state_r);
  assign trig_ok_s     = beat_s & trig_hit & trig_en & ~cons_mode &
                         ((state_r == ST_ARMED) | ((state_r == ST_PRE) & ~pre_fill_req));
  assign last_slot_s   = (nxt_addr_r == (depth - ONE_C));
  // Without a trigger the capture ends on the first write to the top slot.
  assign stop_s        = beat_s & ~trig_en & ~cons_mode & last_slot_s;

  // Capture FSM and result registers.
  always_comb begin
    state_nxt_s    = state_r;
    pre_cnt_nxt_s  = pre_cnt_r;
    post_cnt_nxt_s = post_cnt_r;
    trig_pos_nxt_s = trig_pos_r;
    sd_saddr_nxt_s = sd_saddr_r;
    done_nxt_s     = 1'b0;
    if (abort_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_nxt_s    = ST_PRE;
            pre_cnt_nxt_s  = ZERO_C;
            trig_pos_nxt_s = ZERO_C;
            sd_saddr_nxt_s = ZERO_C;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_PRE, ST_ARMED: begin
          if (trig_ok_s) begin
            trig_pos_nxt_s = (pre_cnt_r < pre_eff_s) ? pre_cnt_r : pre_eff_s;
            post_cnt_nxt_s = ONE_C;
            state_nxt_s    = (post_len_s == ONE_C) ? ST_DONE : ST_POST;
          end else if (stop_s) begin
            state_nxt_s = ST_DONE;
          end else if (state_r == ST_PRE) begin
            pre_cnt_nxt_s = pre_cnt_inc_s;
            state_nxt_s   = (pre_cnt_inc_s >= pre_eff_s) ? ST_ARMED : ST_PRE;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_POST: begin
          if (beat_s) begin
            if (post_cnt_r == (post_len_s - ONE_C)) begin
              state_nxt_s = ST_DONE;
            end else begin
              post_cnt_nxt_s = post_cnt_r + ONE_C;
            end
          end else begin
            state_nxt_s = ST_POST;
          end
        end
        ST_DONE: begin
          done_nxt_s     = 1'b1;
          sd_saddr_nxt_s = wrapped_r ? nxt_addr_r : ZERO_C;
          state_nxt_s    = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Ring address bookkeeping; nxt_addr_r is the slot the next beat lands in.
  always_comb begin
    wr_addr_nxt_s  = wr_addr_r;
    nxt_addr_nxt_s = nxt_addr_r;
    wrapped_nxt_s  = wrapped_r;
    if ((state_r == ST_IDLE) && start_s) begin
      wr_addr_nxt_s  = ZERO_C;
      nxt_addr_nxt_s = ZERO_C;
      wrapped_nxt_s  = 1'b0;
    end else if (beat_s) begin
      wr_addr_nxt_s  = nxt_addr_r;
      nxt_addr_nxt_s = last_slot_s ? ZERO_C : (nxt_addr_r + ONE_C);
      wrapped_nxt_s  = wrapped_r | last_slot_s;
    end else begin
      wr_addr_nxt_s = wr_addr_r;
    end
  end

  // State and output registers.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_r         <= ST_IDLE;
      pre_cnt_r       <= ZERO_C;
      post_cnt_r      <= ZERO_C;
      nxt_addr_r      <= ZERO_C;
      wr_addr_r       <= ZERO_C;
      sd_saddr_r      <= ZERO_C;
      trig_pos_r      <= ZERO_C;
      wrapped_r       <= 1'b0;
      sample_en_d_r   <= 1'b0;
      capture_valid_r <= 1'b0;
      capture_data_r  <= {DW{1'b0}};
      capture_done_r  <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      pre_cnt_r       <= pre_cnt_nxt_s;
      post_cnt_r      <= post_cnt_nxt_s;
      nxt_addr_r      <= nxt_addr_nxt_s;
      wr_addr_r       <= wr_addr_nxt_s;
      sd_saddr_r      <= sd_saddr_nxt_s;
      trig_pos_r      <= trig_pos_nxt_s;
      wrapped_r       <= wrapped_nxt_s;
      sample_en_d_r   <= sample_en;
      capture_valid_r <= beat_s;
      capture_done_r  <= done_nxt_s;
      busy_r          <= is_busy_state(state_nxt_s);
      if (beat_s) begin
        capture_data_r <= dd_s;
      end else begin
        capture_data_r <= capture_data_r;
      end
    end
  end

  assign capture_valid = capture_valid_r;
  assign capture_data  = capture_data_r;
  assign wr_addr       = wr_addr_r;
  assign capture_done  = capture_done_r;
  assign sd_saddr      = sd_saddr_r;
  assign trig_real_pos = trig_pos_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_capture_ring_ctrl.sv
// Directed table-driven bench for capture_ring_ctrl plus hand-written corner sequences.
module tb_capture_ring_ctrl;

  localparam int DW  = 16;
  localparam int CW  = 32;
  localparam int FIX = 3;
  localparam int DLW = 4;

  logic          core_clk = 1'b0;
  logic          core_rst;
  logic          sample_en, cons_mode, trig_en, pre_fill_req;
  logic [CW-1:0] depth, pre_depth;
  logic [DLW-1:0] trig_dly;
  logic          trig_hit, sample_valid;
  logic [DW-1:0] sample_data;
  logic          capture_valid, capture_done, busy;
  logic [DW-1:0] capture_data;
  logic [CW-1:0] wr_addr, sd_saddr, trig_real_pos;

  int checks = 0;
  int errors = 0;

  capture_ring_ctrl dut (
    .core_clk      (core_clk),
    .core_rst      (core_rst),
    .sample_en     (sample_en),
    .cons_mode     (cons_mode),
    .trig_en       (trig_en),
    .pre_fill_req  (pre_fill_req),
    .depth         (depth),
    .pre_depth     (pre_depth),
    .trig_dly      (trig_dly),
    .trig_hit      (trig_hit),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .capture_valid (capture_valid),
    .capture_data  (capture_data),
    .wr_addr       (wr_addr),
    .capture_done  (capture_done),
    .sd_saddr      (sd_saddr),
    .trig_real_pos (trig_real_pos),
    .busy          (busy)
  );

  initial forever #5 core_clk = ~core_clk;

  typedef struct {
    int depth; int pre; int dly; int ten; int pf; int cons;
    int n_drive; int t1; int t2;
    int exp_valid; int exp_done; int exp_sd; int exp_pos;
  } scn_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cv"},   32'(capture_valid), 0);
    chk({tag, "_data"}, 32'(capture_data),  0);
    chk({tag, "_addr"}, wr_addr,            0);
    chk({tag, "_done"}, 32'(capture_done),  0);
    chk({tag, "_sd"},   sd_saddr,           0);
    chk({tag, "_pos"},  trig_real_pos,      0);
    chk({tag, "_busy"}, 32'(busy),          0);
  endtask

  task automatic set_cfg(input int dep, input int pre, input int dly,
                         input logic ten, input logic pf, input logic cons);
    @(negedge core_clk);
    depth = CW'(dep); pre_depth = CW'(pre); trig_dly = DLW'(dly);
    trig_en = ten; pre_fill_req = pf; cons_mode = cons;
    sample_en = 1'b0; sample_valid = 1'b0; trig_hit = 1'b0; sample_data = 16'h0000;
    repeat (24) @(negedge core_clk);
  endtask

  // Continuous beats from cycle 0; beat k carries A000+k and is captured at cycle k+lat.
  task automatic run_scn(input scn_t s, input string nm);
    int lat, n_cv, n_done, done_cyc, k;
    logic seq_ok;
    lat = FIX + s.dly + 2;
    n_cv = 0; n_done = 0; done_cyc = -1; seq_ok = 1'b1;
    set_cfg(s.depth, s.pre, s.dly, s.ten[0], s.pf[0], s.cons[0]);
    for (int c = 0; c < s.n_drive + lat + 8; c++) begin
      if (c > 0) @(negedge core_clk);
      if (capture_valid === 1'b1) begin
        if (c != n_cv + lat || wr_addr !== CW'(n_cv % s.depth) ||
            capture_data !== DW'(32'hA000 + n_cv)) seq_ok = 1'b0;
        n_cv++;
      end
      if (capture_done === 1'b1) begin
        n_done++;
        done_cyc = c;
      end
      k = c - (lat - 1);
      sample_en    = 1'b1;
      sample_valid = (c < s.n_drive);
      sample_data  = DW'(32'hA000 + c);
      trig_hit     = (k == s.t1) || (k == s.t2);
    end
    chk({nm, "_valid_cnt"}, n_cv, s.exp_valid);
    chk({nm, "_done_cnt"}, n_done, s.exp_done);
    chk({nm, "_seq"}, 32'(seq_ok), 1);
    chk({nm, "_done_cyc"}, done_cyc, (s.exp_done != 0) ? (s.exp_valid + lat) : -1);
    chk({nm, "_sd_saddr"}, sd_saddr, s.exp_sd);
    chk({nm, "_trig_pos"}, trig_real_pos, s.exp_pos);
    chk({nm, "_busy_end"}, 32'(busy), (s.exp_done != 0) ? 0 : 1);
    sample_en = 1'b0; sample_valid = 1'b0; trig_hit = 1'b0;
    repeat (4) @(negedge core_clk);
    chk({nm, "_busy_idle"}, 32'(busy), 0);
  endtask

  scn_t tbl[7];
  string nms[7];

  initial begin
    int n, cyc, dat, ndone;
    tbl[0] = '{8, 3, 0, 1, 0, 0, 20, 10, -100, 15, 1, 7, 3};
    tbl[1] = '{8, 4, 0, 1, 0, 0, 10,  2, -100,  6, 1, 0, 2};
    tbl[2] = '{8, 4, 2, 1, 1, 0, 14,  2,    6, 10, 1, 2, 4};
    tbl[3] = '{5, 2, 1, 0, 0, 0,  9,  1, -100,  5, 1, 0, 0};
    tbl[4] = '{4, 1, 0, 1, 0, 1, 10,  3, -100, 10, 0, 0, 0};
    tbl[5] = '{6, 9, 5, 1, 0, 0, 12,  7, -100,  8, 1, 2, 5};
    tbl[6] = '{4, 0, 3, 1, 0, 0, 10,  2, -100,  6, 1, 2, 0};
    nms = '{"wrap", "early_trig", "prefill", "no_trig", "stream", "clamp", "pre_zero"};

    core_rst = 1'b1;
    sample_en = 1'b0; cons_mode = 1'b0; trig_en = 1'b0; pre_fill_req = 1'b0;
    depth = 32'd8; pre_depth = 32'd3; trig_dly = 4'd0;
    trig_hit = 1'b0; sample_valid = 1'b0; sample_data = 16'h0000;
    repeat (3) @(negedge core_clk);
    chk_zero("reset");
    core_rst = 1'b0;

    for (int i = 0; i < 7; i++) run_scn(tbl[i], nms[i]);

    // Single beat through the longest chosen alignment delay.
    set_cfg(8, 3, 5, 1'b1, 1'b0, 1'b0);
    n = 0; cyc = -1; dat = 0;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge core_clk);
      if (capture_valid === 1'b1) begin
        n++; cyc = c; dat = 32'(capture_data);
      end
      sample_en    = 1'b1;
      sample_valid = (c == 0);
      sample_data  = (c == 0) ? 16'h5A3C : 16'h0000;
      trig_hit     = 1'b0;
    end
    chk("lat_cycle", cyc, 10);
    chk("lat_count", n, 1);
    chk("lat_data", dat, 32'h5A3C);

    // Drop sample_en while in POST (beat 12 of a trigger-at-10 window).
    set_cfg(8, 3, 0, 1'b1, 1'b0, 1'b0);
    n = 0; ndone = 0;
    for (int c = 0; c < 31; c++) begin
      if (c > 0) @(negedge core_clk);
      if (c == 17) begin
        chk("abort_pre_busy", 32'(busy), 1);
        chk("abort_pre_cv", 32'(capture_valid), 1);
      end
      if (c == 18) begin
        chk("abort_busy", 32'(busy), 0);
        chk("abort_cv", 32'(capture_valid), 0);
      end
      if (c >= 18) begin
        n += 32'(capture_valid);
        ndone += 32'(capture_done);
      end
      sample_en    = (c < 17);
      sample_valid = 1'b1;
      sample_data  = DW'(32'hA000 + c);
      trig_hit     = ((c - 4) == 10);
    end
    chk("abort_tail_cv", n, 0);
    chk("abort_no_done", ndone, 0);
    chk("abort_trig_pos", trig_real_pos, 3);
    chk("abort_sd_saddr", sd_saddr, 0);

    // Asynchronous reset in the middle of POST.
    set_cfg(8, 3, 0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge core_clk);
      if (c == 17) chk("rst_pre_cv", 32'(capture_valid), 1);
      sample_en    = 1'b1;
      sample_valid = 1'b1;
      sample_data  = DW'(32'hA000 + c);
      trig_hit     = ((c - 4) == 10);
    end
    #2 core_rst = 1'b1;
    #1 chk_zero("mid_rst");
    @(negedge core_clk);
    core_rst = 1'b0; sample_en = 1'b0; sample_valid = 1'b0; trig_hit = 1'b0;
    repeat (3) @(negedge core_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
